// File: rtl/pos_cache_mc.sv
// pos_cache_mc: double-buffered particle position cache for one cell.
//
// Two banks hold particle positions. Address 0 of a bank holds the particle
// count and addresses 1..N hold {posz,posy,posx}. Reads always go to the
// active bank. While a motion update is broadcast, every channel whose
// destination equals this cell is queued in a small FIFO. The FIFO drains
// one entry per cycle into the inactive bank. After the broadcast the count
// is written to address 0 and the banks swap.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   motion_update_enable   held high for the whole update broadcast
//   in_read_address        read address into the active bank
//   in_rden                read enable, 1-cycle latency, output holds when low
//   in_data                NUM_CH x {posz,posy,posx}, channel k at slice k
//   in_data_dst_cell       NUM_CH x {x,y,z} destination cell IDs
//   in_data_valid          per-channel valid
//   out_particle_info      read data
//   out_busy               high whenever the update FSM is not IDLE
//   out_overflow           sticky drop flag (status build only)
//   out_drop_count         saturating drop counter (status build only)
//
// Build option: define POS_CACHE_MC_STATUS_EN to get the overflow flag and the
// drop counter. Without it both outputs are tied to 0, and drops still
// happen silently.
module pos_cache_mc #(
    parameter int    DATA_WIDTH    = 32,
    parameter int    PARTICLE_NUM  = 220,
    parameter int    ADDR_WIDTH    = 8,
    parameter int    CELL_ID_WIDTH = 4,
    parameter int    CELL_X        = 1,
    parameter int    CELL_Y        = 1,
    parameter int    CELL_Z        = 1,
    parameter int    NUM_CH        = 2,
    parameter int    FIFO_DEPTH    = 8,
    parameter string INIT_FILE     = ""
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              motion_update_enable,
    input  logic [ADDR_WIDTH-1:0]             in_read_address,
    input  logic                              in_rden,
    input  logic [NUM_CH*3*DATA_WIDTH-1:0]    in_data,
    input  logic [NUM_CH*3*CELL_ID_WIDTH-1:0] in_data_dst_cell,
    input  logic [NUM_CH-1:0]                 in_data_valid,
    output logic [3*DATA_WIDTH-1:0]           out_particle_info,
    output logic                              out_busy,
    output logic                              out_overflow,
    output logic [ADDR_WIDTH-1:0]             out_drop_count
);

    localparam int DW3     = 3 * DATA_WIDTH;
    localparam int CW3     = 3 * CELL_ID_WIDTH;
    localparam int DEPTH_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = DEPTH_W + 1;

    localparam logic [CW3-1:0] MY_CELL = {CELL_ID_WIDTH'(CELL_X),
                                          CELL_ID_WIDTH'(CELL_Y),
                                          CELL_ID_WIDTH'(CELL_Z)};
    localparam logic [ADDR_WIDTH-1:0] PN_A  = ADDR_WIDTH'(PARTICLE_NUM);
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_WRITE_NUM,
        S_SWAP
    } state_t;

    state_t                r_state;
    logic                  r_active;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;

    // One registered write port, always aimed at the inactive bank
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DW3-1:0]        r_wdata;

    logic [DW3-1:0] r_bank0 [2**ADDR_WIDTH];
    logic [DW3-1:0] r_bank1 [2**ADDR_WIDTH];

    logic [DW3-1:0]     r_fifo [FIFO_DEPTH];
    logic [DEPTH_W-1:0] r_fifo_rd;
    logic [DEPTH_W-1:0] r_fifo_wr;
    logic [CNT_W-1:0]   r_fifo_cnt;

    logic                            w_accept;
    logic [NUM_CH-1:0]               w_match;
    logic [NUM_CH-1:0]               w_push;
    logic [CNT_W-1:0]                w_push_cnt;
    logic [CNT_W-1:0]                w_free;
    logic [NUM_CH-1:0][DEPTH_W-1:0]  w_slot;
    logic                            w_pop;
    logic                            w_cap_drop;
    logic [DW3-1:0]                  w_fifo_head;

    // Matches are accepted in the cycle the FSM leaves IDLE and throughout COLLECT
    assign w_accept = ((r_state == S_IDLE) && motion_update_enable) || (r_state == S_COLLECT);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_match
        assign w_match[k] = w_accept && in_data_valid[k]
                            && (in_data_dst_cell[k*CW3 +: CW3] == MY_CELL);
    end

    // The pop does not count toward free space. An entry pushed this cycle
    // cannot also be written in the same cycle.
    assign w_free      = CNT_W'(FIFO_DEPTH) - r_fifo_cnt;
    assign w_pop       = ((r_state == S_COLLECT) || (r_state == S_DRAIN)) && (r_fifo_cnt != '0);
    assign w_cap_drop  = w_pop && (r_wr_ptr > PN_A);
    assign w_fifo_head = r_fifo[r_fifo_rd];

    // Channels are granted slots in ascending order, so when space runs out
    // the highest channels are the ones dropped
    always_comb begin
        w_push     = '0;
        w_push_cnt = '0;
        w_slot     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_slot[k] = r_fifo_wr + DEPTH_W'(w_push_cnt);
            if (w_match[k] && (w_push_cnt < w_free)) begin
                w_push[k]  = 1'b1;
                w_push_cnt = w_push_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_push[k]) r_fifo[w_slot[k]] <= in_data[k*DW3 +: DW3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_SWAP)) begin
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_fifo_cnt <= '0;
        end else begin
            r_fifo_rd  <= r_fifo_rd + DEPTH_W'(w_pop);
            r_fifo_wr  <= r_fifo_wr + DEPTH_W'(w_push_cnt);
            r_fifo_cnt <= r_fifo_cnt + w_push_cnt - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
            r_wr_ptr <= ONE_A;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= 1'b0;
            // An entry popped past capacity is discarded and the pointer stays put
            if (w_pop && !w_cap_drop) begin
                r_we     <= 1'b1;
                r_waddr  <= r_wr_ptr;
                r_wdata  <= w_fifo_head;
                r_wr_ptr <= r_wr_ptr + ONE_A;
            end
            case (r_state)
                S_IDLE:      if (motion_update_enable) r_state <= S_COLLECT;
                S_COLLECT:   if (!motion_update_enable) r_state <= S_DRAIN;
                S_DRAIN:     if ((r_fifo_cnt == '0) && !r_we) r_state <= S_WRITE_NUM;
                S_WRITE_NUM: begin
                    r_we    <= 1'b1;
                    r_waddr <= '0;
                    r_wdata <= {{(DW3-ADDR_WIDTH){1'b0}}, r_wr_ptr - ONE_A};
                    r_state <= S_SWAP;
                end
                S_SWAP: begin
                    // The count write lands on this edge, and it still uses the old r_active
                    r_active <= ~r_active;
                    r_wr_ptr <= ONE_A;
                    r_state  <= S_IDLE;
                end
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (r_we && !rst && r_active) r_bank0[r_waddr] <= r_wdata;
    end

    always @(posedge clk) begin
        if (r_we && !rst && !r_active) r_bank1[r_waddr] <= r_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)          out_particle_info <= '0;
        else if (in_rden) out_particle_info <= r_active ? r_bank1[in_read_address]
                                                        : r_bank0[in_read_address];
    end

    assign out_busy = (r_state != S_IDLE);

`ifdef POS_CACHE_MC_STATUS_EN
    localparam int DROP_W = $clog2(NUM_CH + 2);

    logic [DROP_W-1:0]     w_drop_num;
    logic [ADDR_WIDTH:0]   w_drop_sum;
    logic                  w_start;
    logic                  r_overflow;
    logic [ADDR_WIDTH-1:0] r_drop_count;

    // This cycle's drops are FIFO-full rejections plus any capacity drop
    always_comb begin
        w_drop_num = DROP_W'(w_cap_drop);
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_match[k] && !w_push[k]) w_drop_num = w_drop_num + DROP_W'(1);
        end
    end

    assign w_start    = (r_state == S_IDLE) && motion_update_enable;
    assign w_drop_sum = (w_start ? '0 : {1'b0, r_drop_count}) + (ADDR_WIDTH+1)'(w_drop_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_overflow   <= (r_overflow && !w_start) || (w_drop_num != '0);
            r_drop_count <= w_drop_sum[ADDR_WIDTH] ? '1 : w_drop_sum[ADDR_WIDTH-1:0];
        end
    end

    assign out_overflow   = r_overflow;
    assign out_drop_count = r_drop_count;
`else
    assign out_overflow   = 1'b0;
    assign out_drop_count = '0;
`endif

endmodule

// File: tb/tb_pos_cache_mc.sv
module tb_pos_cache_mc;

    localparam logic [11:0] SELF = {4'd1, 4'd1, 4'd1};

    logic         clk = 1'b0;
    logic         rst;
    logic         motion_update_enable;
    logic [7:0]   in_read_address;
    logic         in_rden;
    logic [191:0] in_data;
    logic [23:0]  in_data_dst_cell;
    logic [1:0]   in_data_valid;

    logic [95:0]  a_info, b_info;
    logic         a_busy, b_busy, a_ovf, b_ovf;
    logic [7:0]   a_drop, b_drop;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pos_cache_mc dut_a (
        .clk(clk), .rst(rst), .motion_update_enable(motion_update_enable),
        .in_read_address(in_read_address), .in_rden(in_rden), .in_data(in_data),
        .in_data_dst_cell(in_data_dst_cell), .in_data_valid(in_data_valid),
        .out_particle_info(a_info), .out_busy(a_busy),
        .out_overflow(a_ovf), .out_drop_count(a_drop)
    );

    pos_cache_mc #(.FIFO_DEPTH(2), .PARTICLE_NUM(4)) dut_b (
        .clk(clk), .rst(rst), .motion_update_enable(motion_update_enable),
        .in_read_address(in_read_address), .in_rden(in_rden), .in_data(in_data),
        .in_data_dst_cell(in_data_dst_cell), .in_data_valid(in_data_valid),
        .out_particle_info(b_info), .out_busy(b_busy),
        .out_overflow(b_ovf), .out_drop_count(b_drop)
    );

    // Reference model: bank images plus a known flag per word, one per instance
    int          depth [2] = '{8, 2};
    int          pnum  [2] = '{220, 4};
    logic [95:0] mb   [2][2][256];
    bit          mk   [2][2][256];
    int          mact [2];
    int          mdrop[2];
    bit          movf [2];
    logic [95:0] last_exp [2];
    bit          last_kn  [2];

    // Per-cycle stimulus for one update
    logic [95:0] st_d   [16][2];
    bit          st_v   [16][2];
    bit          st_h   [16][2];
    logic [11:0] st_dst [16][2];

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] info(input int i);
        return (i == 0) ? a_info : b_info;
    endfunction

    task automatic set_cyc(input int c, input bit v0, input bit h0, input bit v1, input bit h1);
        logic [11:0] m;
        st_v[c][0] = v0; st_h[c][0] = h0;
        st_v[c][1] = v1; st_h[c][1] = h1;
        for (int ch = 0; ch < 2; ch++) begin
            st_d[c][ch] = {$urandom, $urandom, $urandom};
            m = 12'($urandom);
            if (m == SELF) m = m ^ 12'h001;
            st_dst[c][ch] = m;
        end
    endtask

    task automatic check_status(input string tag);
        for (int i = 0; i < 2; i++) begin
`ifdef POS_CACHE_MC_STATUS_EN
            chk($sformatf("%s_ovf%0d", tag, i), {95'd0, (i == 0) ? a_ovf : b_ovf}, {95'd0, movf[i]});
            chk($sformatf("%s_drop%0d", tag, i), {88'd0, (i == 0) ? a_drop : b_drop}, 96'(mdrop[i]));
`else
            chk($sformatf("%s_ovf%0d", tag, i), {95'd0, (i == 0) ? a_ovf : b_ovf}, 96'd0);
            chk($sformatf("%s_drop%0d", tag, i), {88'd0, (i == 0) ? a_drop : b_drop}, 96'd0);
`endif
        end
    endtask

    task automatic read_check(input int addr);
        in_rden = 1'b1;
        in_read_address = 8'(addr);
        step();
        in_rden = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_kn[i]  = mk[i][mact[i]][addr];
            last_exp[i] = mb[i][mact[i]][addr];
            if (last_kn[i]) chk($sformatf("rd%0d_a%0d", i, addr), info(i), last_exp[i]);
        end
    endtask

    // Model of one update: the FIFO fills by occupancy arithmetic and pops one
    // entry per cycle. Entries are written in arrival order until capacity is reached.
    task automatic model_update(input int i, input int len);
        logic [95:0] acc[$];
        int occ, free, pushed, drops, nw, inact;
        bit popping;
        occ = 0; drops = 0;
        for (int c = 0; c < len; c++) begin
            popping = (occ > 0);
            free = depth[i] - occ;
            pushed = 0;
            for (int ch = 0; ch < 2; ch++) begin
                if (st_v[c][ch] && st_h[c][ch]) begin
                    if (pushed < free) begin
                        acc.push_back(st_d[c][ch]);
                        pushed++;
                    end else drops++;
                end
            end
            occ = occ + pushed - (popping ? 1 : 0);
        end
        nw = (acc.size() < pnum[i]) ? acc.size() : pnum[i];
        drops += acc.size() - nw;
        inact = 1 - mact[i];
        for (int j = 0; j < nw; j++) begin
            mb[i][inact][j+1] = acc[j];
            mk[i][inact][j+1] = 1'b1;
        end
        mb[i][inact][0] = 96'(nw);
        mk[i][inact][0] = 1'b1;
        mact[i] = inact;
        movf[i]  = (drops > 0);
        mdrop[i] = (drops > 255) ? 255 : drops;
    endtask

    task automatic do_update(input string tag, input int len);
        int n;
        for (int c = 0; c < len; c++) begin
            motion_update_enable = 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                in_data[ch*96 +: 96]          = st_d[c][ch];
                in_data_dst_cell[ch*12 +: 12] = st_h[c][ch] ? SELF : st_dst[c][ch];
                in_data_valid[ch]             = st_v[c][ch];
            end
            step();
            if (c == 0) begin
                chk({tag, "_busy_a"}, {95'd0, a_busy}, 96'd1);
                chk({tag, "_busy_b"}, {95'd0, b_busy}, 96'd1);
            end
        end
        motion_update_enable = 1'b0;
        in_data_valid = 2'b00;
        n = 0;
        while ((a_busy || b_busy) && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_done"}, {95'd0, (n < 400)}, 96'd1);
        for (int i = 0; i < 2; i++) model_update(i, len);
        check_status(tag);
        for (int a = 0; a < 15; a++) read_check(a);
    endtask

    initial begin
        int picks, sel;
        rst = 1'b1;
        motion_update_enable = 1'b0;
        in_read_address = '0;
        in_rden = 1'b0;
        in_data = '0;
        in_data_dst_cell = '0;
        in_data_valid = '0;
        for (int i = 0; i < 2; i++) begin
            mact[i] = 0; mdrop[i] = 0; movf[i] = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 256; a++) begin mk[i][b][a] = 1'b0; mb[i][b][a] = '0; end
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_busy_a", {95'd0, a_busy}, 96'd0);
        chk("rst_busy_b", {95'd0, b_busy}, 96'd0);
        chk("rst_info_a", a_info, 96'd0);
        chk("rst_info_b", b_info, 96'd0);
        check_status("rst");

        // Both channels match for three cycles
        for (int c = 0; c < 3; c++) set_cyc(c, 1, 1, 1, 1);
        do_update("dual", 3);

        // Only ch1 matches, in four of ten cycles
        picks = 0;
        for (int c = 0; c < 10; c++) begin
            sel = ((picks < 4) && (($urandom_range(0, 1) == 1) || (10 - c == 4 - picks))) ? 1 : 0;
            picks += sel;
            set_cyc(c, 1, 0, (sel == 1) ? 1'b1 : 1'($urandom_range(0, 1)), sel == 1);
        end
        do_update("mixed", 10);

        // Both channels match for four cycles, so the small FIFO overflows
        for (int c = 0; c < 4; c++) set_cyc(c, 1, 1, 1, 1);
        do_update("ovf", 4);

        // Six single-channel matches against the 4-particle instance
        for (int c = 0; c < 6; c++) set_cyc(c, 1, 1, 0, 0);
        do_update("cap", 6);

        // Read output holds while rden is low
        read_check(2);
        in_read_address = 8'd3;
        step();
        for (int i = 0; i < 2; i++)
            if (last_kn[i]) chk($sformatf("hold%0d", i), info(i), last_exp[i]);

        // Abort after two matching cycles
        motion_update_enable = 1'b1;
        in_data_dst_cell = {SELF, SELF};
        in_data_valid = 2'b11;
        step();
        step();
        rst = 1'b1;
        motion_update_enable = 1'b0;
        in_data_valid = 2'b00;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 256; a++) mk[i][1-mact[i]][a] = 1'b0;
            mact[i] = 0; movf[i] = 1'b0; mdrop[i] = 0;
        end
        chk("abort_busy_a", {95'd0, a_busy}, 96'd0);
        chk("abort_busy_b", {95'd0, b_busy}, 96'd0);
        chk("abort_info_a", a_info, 96'd0);
        check_status("abort");
        for (int a = 0; a < 8; a++) read_check(a);
        for (int c = 0; c < 3; c++) set_cyc(c, 1, 1, 1, 1);
        do_update("post_rst", 3);

        // Randomised updates
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++)
                set_cyc(c, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
            do_update($sformatf("rnd%0d", r), len);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
